// File: rtl/mips_pkg.sv
// Shared MIPS MEM-stage definitions: access FSM state encoding and bus constants.
package mips_pkg;

  localparam int TIMEOUT_W = 8;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// WAIT-cycle counter for mem_access_ctrl; only present when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr
  import mips_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Terminal count fires in the cycle whose increment would reach LIMIT.
  assign tc_o = en_i && (cnt_q == TIMEOUT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: req/ack bus transaction with pipeline stall.
// Define MEM_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles without mem_ack.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM
);

  mem_state_e state_q;
  logic       access;
  logic       aligned;
  logic       timeoutHit;

  assign access  = MemtoRegM | MemWriteM;
  assign aligned = (ALUOutM[1:0] & WORD_ALIGN_MASK) == 2'b00;
  assign StallM  = (state_q == IDLE && access) || (state_q == WAIT);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != WAIT),
    .en_i  (state_q == WAIT && !mem_ack),
    .tc_o  (timeoutHit)
  );
`else
  // No counter: WAIT waits indefinitely and TIMEOUT has no effect.
  assign timeoutHit = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      MemErrM   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= MemWriteM;
              mem_addr  <= ALUOutM;
              mem_wdata <= WriteDataM;
              state_q   <= WAIT;
            end else begin
              MemErrM   <= 1'b1;
              ReadDataM <= '0;
              state_q   <= DONE;
            end
          end
        end
        WAIT: begin
          // Ack beats a simultaneous timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              ReadDataM <= mem_rdata;
            end
            state_q <= DONE;
          end else if (timeoutHit) begin
            mem_req   <= 1'b0;
            MemErrM   <= 1'b1;
            ReadDataM <= '0;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized ops
// checked against a transaction-level model of stalls, bus activity and results.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int TB_TIMEOUT = 3;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TB_TIMEOUT = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        MemtoRegM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, ReadDataM;
   logic        StallM, MemErrM;

   int testsRun = 0;
   int testsFailed = 0;

   logic [31:0] modelRead;
   logic        modelErr;

   typedef struct {
      int          stalls;
      int          waits;
      int          reqs;
      int          unstable;
      bit          timedOut;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] readData;
      logic        err;
      logic        reqAfterDone;
   } obs_t;

   typedef struct {
      int          stalls;
      int          waits;
      int          reqs;
      logic [31:0] readData;
      logic        err;
   } exp_t;

   mem_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemtoRegM  (MemtoRegM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .MemErrM    (MemErrM)
   );

   always #5 clk = ~clk;

   // Transaction-level expectation: stall = 1 detect cycle + bus wait cycles.
   function automatic exp_t predict(input bit ld, input bit st, input logic [31:0] addr,
                                    input logic [31:0] rd, input int ackAfter);
      exp_t e;
      bit abort;
      e.readData = modelRead;
      e.err      = modelErr;
      if (addr % 4 != 0) begin
         e.stalls = 1; e.waits = 0; e.reqs = 0; e.readData = 32'd0; e.err = 1'b1;
      end else begin
         abort = TO_EN && (ackAfter == 0 || ackAfter > TB_TIMEOUT);
         e.waits  = abort ? TB_TIMEOUT : ackAfter;
         e.stalls = 1 + e.waits;
         e.reqs   = 1;
         if (abort) begin
            e.err = 1'b1; e.readData = 32'd0;
         end else if (!st) begin
            e.readData = rd;
         end
      end
      return e;
   endfunction

   // Drives one MEM-stage op and plays the memory side; called at a negedge in IDLE.
   task automatic applyStimulus(input bit ld, input bit st, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int ackAfter, output obs_t o);
      bit done = 1'b0;
      bit prevReq;
      o = '{default: 0};
      prevReq = mem_req;
      MemtoRegM = ld; MemWriteM = st; ALUOutM = addr; WriteDataM = wd; mem_ack = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         #1;
         if (mem_req === 1'b1) begin
            if (o.waits == 0) begin
               o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
            end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata) begin
               o.unstable++;
            end
            if (!prevReq) o.reqs++;
            o.waits++;
            if (o.waits == ackAfter) begin
               mem_ack = 1'b1; mem_rdata = rd;
            end
         end
         prevReq = mem_req;
         if (StallM === 1'b1) o.stalls++;
         else begin
            done = 1'b1;
            o.readData = ReadDataM;
            o.err = MemErrM;
         end
         @(negedge clk);
         mem_ack = 1'b0;
         mem_rdata = $urandom;
      end
      o.timedOut = !done;
      #1;
      o.reqAfterDone = mem_req;
      MemtoRegM = 1'b0; MemWriteM = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      MemtoRegM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'd0; WriteDataM = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      testsRun++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, MemErrM} !== 99'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rd=%h err=%b want all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, MemErrM);
      end
      reset = 1'b0;
      @(negedge clk); #1;
      testsRun++;
      if (StallM !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_idle_stall: got %b want 0", StallM);
      end
      modelRead = 32'd0; modelErr = 1'b0;
   endtask

   task automatic test_load_basic();
      obs_t o; exp_t e;
      e = predict(1'b1, 1'b0, 32'h10, 32'h1234_5678, 1);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1, o);
      testsRun++;
      if (o.stalls !== e.stalls) begin testsFailed++; $display("[TB] FAIL load_stalls: got %0d want %0d", o.stalls, e.stalls); end
      testsRun++;
      if (o.we !== 1'b0 || o.addr !== 32'h10) begin testsFailed++; $display("[TB] FAIL load_bus: got we=%b addr=%h want we=0 addr=00000010", o.we, o.addr); end
      testsRun++;
      if (o.readData !== 32'h1234_5678) begin testsFailed++; $display("[TB] FAIL load_data: got %h want 12345678", o.readData); end
      testsRun++;
      if (o.err !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_err: got %b want 0", o.err); end
      modelRead = e.readData; modelErr = e.err;
   endtask

   task automatic test_store();
      obs_t o; exp_t e;
      e = predict(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4);
      applyStimulus(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4, o);
      testsRun++;
      if (o.stalls !== e.stalls || o.waits !== e.waits) begin testsFailed++; $display("[TB] FAIL store_timing: got stalls=%0d waits=%0d want %0d/%0d", o.stalls, o.waits, e.stalls, e.waits); end
      testsRun++;
      if (o.we !== 1'b1 || o.addr !== 32'h20 || o.wdata !== 32'hCAFE_F00D || o.unstable !== 0) begin
         testsFailed++;
         $display("[TB] FAIL store_bus: got we=%b addr=%h wdata=%h unstable=%0d want 1/00000020/cafef00d/0", o.we, o.addr, o.wdata, o.unstable);
      end
      testsRun++;
      if (o.readData !== e.readData) begin testsFailed++; $display("[TB] FAIL store_rd_unchanged: got %h want %h", o.readData, e.readData); end
      modelRead = e.readData; modelErr = e.err;
   endtask

   task automatic test_misaligned();
      obs_t o; exp_t e;
      e = predict(1'b1, 1'b0, 32'h13, 32'h0, 1);
      applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 32'h5555_AAAA, 1, o);
      testsRun++;
      if (o.reqs !== 0 || o.stalls !== 1) begin testsFailed++; $display("[TB] FAIL misaligned_bus: got reqs=%0d stalls=%0d want 0/1", o.reqs, o.stalls); end
      testsRun++;
      if (o.err !== 1'b1 || o.readData !== 32'd0) begin testsFailed++; $display("[TB] FAIL misaligned_err: got err=%b rd=%h want 1/00000000", o.err, o.readData); end
      modelRead = e.readData; modelErr = e.err;
      e = predict(1'b1, 1'b0, 32'h44, 32'h0BAD_F00D, 2);
      applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, 2, o);
      testsRun++;
      if (o.err !== 1'b1 || o.readData !== e.readData) begin testsFailed++; $display("[TB] FAIL err_sticky: got err=%b rd=%h want 1/%h", o.err, o.readData, e.readData); end
      modelRead = e.readData; modelErr = e.err;
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2; exp_t e1, e2;
      e1 = predict(1'b1, 1'b0, 32'h4, 32'h1111_2222, 1);
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 32'h1111_2222, 1, o1);
      modelRead = e1.readData; modelErr = e1.err;
      e2 = predict(1'b1, 1'b0, 32'h8, 32'h3333_4444, 1);
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h3333_4444, 1, o2);
      testsRun++;
      if (o1.reqs + o2.reqs !== 2 || o1.reqAfterDone !== 1'b0 || o2.reqAfterDone !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_requests: got reqs=%0d dup=%b%b want 2 reqs, dup=00", o1.reqs + o2.reqs, o1.reqAfterDone, o2.reqAfterDone);
      end
      testsRun++;
      if (o1.readData !== e1.readData || o2.readData !== e2.readData) begin
         testsFailed++;
         $display("[TB] FAIL b2b_data: got %h %h want %h %h", o1.readData, o2.readData, e1.readData, e2.readData);
      end
      testsRun++;
      if (o2.addr !== 32'h8 || o1.stalls !== 2 || o2.stalls !== 2) begin
         testsFailed++;
         $display("[TB] FAIL b2b_timing: got addr2=%h stalls=%0d/%0d want 00000008 2/2", o2.addr, o1.stalls, o2.stalls);
      end
      modelRead = e2.readData; modelErr = e2.err;
   endtask

   task automatic test_random();
      obs_t o; exp_t e;
      bit ld, st;
      logic [31:0] addr, wd, rd;
      int ackAfter, gap;
      for (int n = 0; n < 40; n++) begin
         st = $urandom_range(0, 1);
         ld = st ? $urandom_range(0, 1) : 1'b1;
         addr = $urandom & 32'h0000_FFFC;
         if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
         wd = $urandom; rd = $urandom;
         ackAfter = $urandom_range(1, 5);
         e = predict(ld, st, addr, rd, ackAfter);
         applyStimulus(ld, st, addr, wd, rd, ackAfter, o);
         testsRun++;
         if (o.timedOut || o.stalls !== e.stalls || o.reqs !== e.reqs || o.unstable !== 0 || o.reqAfterDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rand_timing[%0d]: got stalls=%0d reqs=%0d unstable=%0d dup=%b hang=%b want %0d/%0d/0/0/0",
                     n, o.stalls, o.reqs, o.unstable, o.reqAfterDone, o.timedOut, e.stalls, e.reqs);
         end
         if (e.reqs == 1) begin
            testsRun++;
            if (o.addr !== addr || o.we !== st || o.wdata !== wd) begin
               testsFailed++;
               $display("[TB] FAIL rand_bus[%0d]: got addr=%h we=%b wdata=%h want %h/%b/%h", n, o.addr, o.we, o.wdata, addr, st, wd);
            end
         end
         testsRun++;
         if (o.readData !== e.readData || o.err !== e.err) begin
            testsFailed++;
            $display("[TB] FAIL rand_result[%0d]: got rd=%h err=%b want %h/%b", n, o.readData, o.err, e.readData, e.err);
         end
         modelRead = e.readData; modelErr = e.err;
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
         end
         mem_ack = 1'b0;
         if (gap > 0) begin
            #1;
            testsRun++;
            if (ReadDataM !== modelRead || mem_req !== 1'b0 || StallM !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL stray_ack[%0d]: got rd=%h req=%b stall=%b want %h/0/0", n, ReadDataM, mem_req, StallM, modelRead);
            end
         end
      end
   endtask

   task automatic test_reset_midwait();
      obs_t o; exp_t e;
      MemtoRegM = 1'b1; ALUOutM = 32'h40; WriteDataM = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      #1;
      testsRun++;
      if (mem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL midwait_req: got %b want 1", mem_req); end
      reset = 1'b1; MemtoRegM = 1'b0;
      @(negedge clk); #1;
      testsRun++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, MemErrM} !== 99'd0) begin
         testsFailed++;
         $display("[TB] FAIL midwait_reset: got req=%b we=%b addr=%h wdata=%h rd=%h err=%b want all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, MemErrM);
      end
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      testsRun++;
      if (mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL midwait_stray_ack: got req=%b stall=%b rd=%h want 0/0/00000000", mem_req, StallM, ReadDataM);
      end
      modelRead = 32'd0; modelErr = 1'b0;
      e = predict(1'b1, 1'b0, 32'h80, 32'h7777_0001, 2);
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 32'h7777_0001, 2, o);
      testsRun++;
      if (o.stalls !== e.stalls || o.readData !== e.readData || o.err !== e.err) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_op: got stalls=%0d rd=%h err=%b want %0d/%h/%b", o.stalls, o.readData, o.err, e.stalls, e.readData, e.err);
      end
      modelRead = e.readData; modelErr = e.err;
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      test_reset();
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 0, o);
      testsRun++;
      if (o.waits !== TB_TIMEOUT || o.stalls !== TB_TIMEOUT + 1 || o.err !== 1'b1 || o.readData !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL timeout_abort: got waits=%0d stalls=%0d err=%b rd=%h want %0d/%0d/1/00000000",
                  o.waits, o.stalls, o.err, o.readData, TB_TIMEOUT, TB_TIMEOUT + 1);
      end
      test_reset();
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 32'hABCD_0123, TB_TIMEOUT, o);
      testsRun++;
      if (o.waits !== TB_TIMEOUT || o.err !== 1'b0 || o.readData !== 32'hABCD_0123) begin
         testsFailed++;
         $display("[TB] FAIL timeout_ack_wins: got waits=%0d err=%b rd=%h want %0d/0/abcd0123", o.waits, o.err, o.readData, TB_TIMEOUT);
      end
      modelRead = 32'hABCD_0123; modelErr = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_load_basic();
      test_store();
      test_misaligned();
      test_back_to_back();
      test_random();
      test_reset_midwait();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
